// File: rtl/cp0_ext_if.sv
// cp0_ext_if: M-stage to coprocessor-0 signal bundle; master is the pipeline, slave is CP0.
interface cp0_ext_if #(parameter int NUM_HWINT = 6);
    logic                 cp_we;
    logic [4:0]           cp_addr;
    logic [31:0]          cp_wdata;
    logic [31:0]          cp_rdata;
    logic [31:0]          vpc;
    logic                 is_bd;
    logic [4:0]           exc_code;
    logic [31:0]          bad_vaddr_in;
    logic [NUM_HWINT-1:0] hw_int;
    logic                 eret;
    logic                 req;
    logic [31:0]          epc_out;
    logic [31:0]          vec_out;
    modport master (
        output cp_we, cp_addr, cp_wdata, vpc, is_bd, exc_code, bad_vaddr_in, hw_int, eret,
        input  cp_rdata, req, epc_out, vec_out
    );
    modport slave (
        input  cp_we, cp_addr, cp_wdata, vpc, is_bd, exc_code, bad_vaddr_in, hw_int, eret,
        output cp_rdata, req, epc_out, vec_out
    );
endinterface

// File: rtl/cp0_ext.sv
// cp0_ext: MIPS CP0 with SR/Cause/EPC/BadVAddr/PRId and exception/interrupt entry.
// Define CP0_TIMER_EN to add the Count/Compare timer driving TI on IP[15].
module cp0_ext #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h0000_0007,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
    input logic      clk,
    input logic      reset,
    cp0_ext_if.slave bus
);
    logic [NUM_HWINT-1:0] hw;
    logic [5:0]           im, ip, ip_now;
    logic                 exl, ie, bd, ti;
    logic [4:0]           exc_code_r;
    logic [31:0]          epc, bad_vaddr, count, compare;
    logic                 int_req, exc_req, wr;
    assign hw = bus.hw_int;
    assign ip_now = 6'(hw) | {ti, 5'b0};
    assign int_req = (|(ip_now & im)) & ie & ~exl & ~reset;
    assign exc_req = (bus.exc_code != 5'd0) & ~reset;
    assign bus.req = int_req | exc_req;
    // a cancelled instruction (req) or an eret never commits an mtc0
    assign wr = bus.cp_we & ~bus.req & ~bus.eret;
    assign bus.epc_out = epc;
    assign bus.vec_out = EXC_VEC;
    assign bus.cp_rdata = (bus.cp_addr == 5'd12) ? {16'b0, im, 8'b0, exl, ie}
                        : (bus.cp_addr == 5'd13) ? {bd, ti, 14'b0, ip, 3'b0, exc_code_r, 2'b0}
                        : (bus.cp_addr == 5'd14) ? epc
                        : (bus.cp_addr == 5'd8)  ? bad_vaddr
                        : (bus.cp_addr == 5'd15) ? PRID_VAL
                        : (bus.cp_addr == 5'd9)  ? count
                        : (bus.cp_addr == 5'd11) ? compare
                        : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            im <= '0;
            exl <= 1'b0;
            ie <= 1'b0;
            bd <= 1'b0;
            ip <= '0;
            exc_code_r <= '0;
            epc <= '0;
            bad_vaddr <= '0;
        end else begin
            ip <= ip_now;
            if (bus.req) begin
                exl <= 1'b1;
                bd <= bus.is_bd;
                epc <= (bus.is_bd ? bus.vpc - 32'd4 : bus.vpc) & ~32'd3;
                exc_code_r <= int_req ? 5'd0 : bus.exc_code;
                if (!int_req && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5))
                    bad_vaddr <= bus.bad_vaddr_in;
            end else if (bus.eret) begin
                exl <= 1'b0;
            end else if (wr) begin
                if (bus.cp_addr == 5'd12)
                    {im, exl, ie} <= {bus.cp_wdata[15:10], bus.cp_wdata[1:0]};
                if (bus.cp_addr == 5'd14)
                    epc <= bus.cp_wdata & ~32'd3;
            end
        end
    end
`ifdef CP0_TIMER_EN
    logic [31:0] count_inc;
    logic        wr_count, wr_compare;
    assign count_inc = count + 32'd1;
    assign wr_count = wr & (bus.cp_addr == 5'd9);
    assign wr_compare = wr & (bus.cp_addr == 5'd11);
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            compare <= '0;
            ti <= 1'b0;
        end else begin
            count <= wr_count ? bus.cp_wdata : count_inc;
            if (wr_compare)
                compare <= bus.cp_wdata;
            // clearing by a Compare write wins over a same-cycle match
            ti <= wr_compare ? 1'b0 : (ti | (~wr_count & (count_inc == compare)));
        end
    end
`else
    assign count = '0;
    assign compare = '0;
    assign ti = 1'b0;
`endif
endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: directed vector table, timer/reset sequences and a randomized run against a
// register-word reference model of cp0_ext.
module tb_cp0_ext;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_ext_if #(.NUM_HWINT(6)) bus();
    cp0_ext #(.NUM_HWINT(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] bad;
        logic [5:0]  hw;
        logic        eret;
        logic [31:0] exp_rd;
        logic        exp_req;
    } vec_t;
    vec_t tbl[$];

    logic [31:0] m_sr, m_cause, m_epc, m_bad, m_count, m_cmp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cp_we = 1'b0;
        bus.cp_addr = 5'd0;
        bus.cp_wdata = '0;
        bus.vpc = '0;
        bus.is_bd = 1'b0;
        bus.exc_code = '0;
        bus.bad_vaddr_in = '0;
        bus.hw_int = '0;
        bus.eret = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                                input logic [31:0] bad, input logic [5:0] hw, input logic eret,
                                input logic [31:0] exp_rd, input logic exp_req);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.vpc = vpc; v.bd = bd; v.exc = exc;
        v.bad = bad; v.hw = hw; v.eret = eret; v.exp_rd = exp_rd; v.exp_req = exp_req;
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bad;
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h0000_0007;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        // req stays low through reset even with an exception code and pending lines
        bus.exc_code = 5'd4;
        bus.hw_int = 6'h3F;
        bus.cp_addr = 5'd15;
        tick();
        #4;
        check("reset_req", {31'b0, bus.req}, 32'h0);
        check("reset_prid", bus.cp_rdata, 32'h0000_0007);
        check("vec_out", bus.vec_out, 32'h0000_4180);
        tick();
        idle();
        reset = 1'b0;

        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 0));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 0));
        tbl.push_back(mk(0, 15, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h7, 0));
        tbl.push_back(mk(1, 12, 32'h0000_FC01, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 0));
        tbl.push_back(mk(0, 12, 0, 32'h3010, 0, 0, 0, 6'b000100, 0, 32'h0000_FC01, 1));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000100, 0, 32'h3010, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 6'b000100, 0, 32'h0000_1000, 0));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_FC03, 0));
        tbl.push_back(mk(0, 14, 0, 32'h3024, 1, 4, 32'h3, 6'b000000, 0, 32'h3010, 1));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h3020, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h8000_0010, 0));
        tbl.push_back(mk(0, 8, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h3, 0));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000000, 1, 32'h3020, 0));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_FC01, 0));
        tbl.push_back(mk(1, 14, 32'hDEAD_0000, 32'h4000, 0, 10, 0, 6'b000001, 0, 32'h3020, 1));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000001, 0, 32'h4000, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_0400, 0));
        tbl.push_back(mk(0, 12, 0, 32'h5000, 0, 10, 0, 6'b000000, 1, 32'h0000_FC03, 1));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_FC03, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_0028, 0));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000000, 1, 32'h5000, 0));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_FC01, 0));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h5000, 0));
        tbl.push_back(mk(1, 12, 32'hFFFF_FFFF, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_FC01, 0));
        tbl.push_back(mk(0, 12, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_FC03, 0));
        tbl.push_back(mk(1, 12, 32'h0, 0, 0, 0, 0, 6'b000000, 0, 32'h0000_FC03, 0));
        tbl.push_back(mk(1, 14, 32'h1237, 0, 0, 0, 0, 6'b000000, 0, 32'h5000, 0));
        tbl.push_back(mk(0, 14, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h1234, 0));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h0, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 6'b111111, 0, 32'h0000_0028, 0));

        foreach (tbl[i]) begin
            bus.cp_we = tbl[i].we;
            bus.cp_addr = tbl[i].addr;
            bus.cp_wdata = tbl[i].wdata;
            bus.vpc = tbl[i].vpc;
            bus.is_bd = tbl[i].bd;
            bus.exc_code = tbl[i].exc;
            bus.bad_vaddr_in = tbl[i].bad;
            bus.hw_int = tbl[i].hw;
            bus.eret = tbl[i].eret;
            #4;
            check($sformatf("vec%0d_rdata", i), bus.cp_rdata, tbl[i].exp_rd);
            check($sformatf("vec%0d_req", i), {31'b0, bus.req}, {31'b0, tbl[i].exp_req});
            tick();
        end

`ifdef CP0_TIMER_EN
        begin
            bit found = 0;
            do_reset();
            bus.cp_we = 1'b1; bus.cp_addr = 5'd11; bus.cp_wdata = 32'd20;
            tick();
            bus.cp_addr = 5'd9; bus.cp_wdata = 32'd10;
            tick();
            bus.cp_addr = 5'd12; bus.cp_wdata = 32'h0000_8001;
            #4;
            check("timer_load", bus.cp_rdata, 32'h0);
            tick();
            idle();
            bus.cp_addr = 5'd9;
            for (int i = 0; i < 40 && !found; i++) begin
                #4;
                if (bus.cp_rdata == 32'd20) begin
                    check("timer_req", {31'b0, bus.req}, 32'h1);
                    found = 1;
                end else begin
                    check("timer_pre_req", {31'b0, bus.req}, 32'h0);
                end
                tick();
            end
            check("timer_reached", {31'b0, found}, 32'h1);
            bus.cp_addr = 5'd13;
            #4;
            check("timer_ti_set", {31'b0, bus.cp_rdata[30]}, 32'h1);
            tick();
            bus.cp_we = 1'b1; bus.cp_addr = 5'd11; bus.cp_wdata = 32'd100;
            tick();
            bus.cp_we = 1'b0; bus.cp_addr = 5'd13;
            #4;
            check("timer_ti_clear", {31'b0, bus.cp_rdata[30]}, 32'h0);
            tick();
            bus.cp_we = 1'b1; bus.cp_addr = 5'd9; bus.cp_wdata = 32'hFFFF_FFFF;
            tick();
            bus.cp_we = 1'b0;
            #4;
            check("timer_max", bus.cp_rdata, 32'hFFFF_FFFF);
            tick();
            #4;
            check("timer_wrap", bus.cp_rdata, 32'h0);
            tick();
        end
`else
        do_reset();
        bus.cp_we = 1'b1; bus.cp_addr = 5'd9; bus.cp_wdata = 32'd123;
        tick();
        bus.cp_addr = 5'd11;
        tick();
        bus.cp_we = 1'b0;
        #4;
        check("no_timer_compare", bus.cp_rdata, 32'h0);
        bus.cp_addr = 5'd9;
        #1;
        check("no_timer_count", bus.cp_rdata, 32'h0);
        tick();
`endif

        do_reset();
        m_sr = 0; m_cause = 0; m_epc = 0; m_bad = 0; m_count = 0; m_cmp = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  pend;
            logic        ireq, ereq, rq, weff, ti_old;
            logic [31:0] nsr, ncause, nepc, nbad, ncount, ncmp, inc;
            int          r;
            r = $urandom_range(0, 8);
            bus.cp_addr = (r == 0) ? 5'd8 : (r == 1) ? 5'd9 : (r == 2) ? 5'd11 : (r == 3) ? 5'd12
                        : (r == 4) ? 5'd13 : (r == 5) ? 5'd14 : (r == 6) ? 5'd15 : 5'($urandom);
            bus.cp_we = ($urandom_range(0, 2) == 0);
            bus.cp_wdata = $urandom;
            bus.vpc = $urandom;
            bus.is_bd = 1'($urandom);
            bus.bad_vaddr_in = $urandom;
            r = $urandom_range(0, 11);
            bus.exc_code = (r == 0) ? 5'd4 : (r == 1) ? 5'd5 : (r == 2) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            bus.eret = ($urandom_range(0, 7) == 0);
            ti_old = m_cause[30];
            pend = bus.hw_int | (ti_old ? 6'b100000 : 6'b000000);
            ireq = ((pend & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
            ereq = (bus.exc_code != 0);
            rq = ireq || ereq;
            #4;
            check("rand_req", {31'b0, bus.req}, {31'b0, rq});
            check("rand_rdata", bus.cp_rdata, m_read(bus.cp_addr));
            check("rand_epc", bus.epc_out, m_epc);
            nsr = m_sr; ncause = m_cause; nepc = m_epc; nbad = m_bad; ncount = m_count; ncmp = m_cmp;
            ncause[15:10] = pend;
            weff = bus.cp_we && !rq && !bus.eret;
            if (rq) begin
                nsr[1] = 1'b1;
                ncause[31] = bus.is_bd;
                ncause[6:2] = ireq ? 5'd0 : bus.exc_code;
                nepc = (bus.is_bd ? bus.vpc - 4 : bus.vpc) & 32'hFFFF_FFFC;
                if (!ireq && (bus.exc_code == 4 || bus.exc_code == 5)) nbad = bus.bad_vaddr_in;
            end else if (bus.eret) begin
                nsr[1] = 1'b0;
            end else if (weff) begin
                if (bus.cp_addr == 12) nsr = bus.cp_wdata & 32'h0000_FC03;
                if (bus.cp_addr == 14) nepc = bus.cp_wdata & 32'hFFFF_FFFC;
            end
`ifdef CP0_TIMER_EN
            inc = m_count + 1;
            ncount = (weff && bus.cp_addr == 9) ? bus.cp_wdata : inc;
            if (weff && bus.cp_addr == 11) begin
                ncmp = bus.cp_wdata;
                ncause[30] = 1'b0;
            end else if (!(weff && bus.cp_addr == 9) && inc == m_cmp) begin
                ncause[30] = 1'b1;
            end
`else
            inc = 0;
`endif
            tick();
            m_sr = nsr; m_cause = ncause; m_epc = nepc; m_bad = nbad; m_count = ncount; m_cmp = ncmp;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
